// File: rtl/zx_xpoint_pkg.sv
// Shared types and constants for the clocked ZX crosspoint keyboard matrix.
// Frame geometry helpers, special-output indices and the stretcher state type.
package zx_xpoint_pkg;

    // Special-switch output indices within SPEC_N
    localparam int SPEC_NMI  = 0;
    localparam int SPEC_RST  = 1;
    localparam int SPEC_BSRQ = 2;

    // Bit positions of the serial pins inside one synchroniser stage
    localparam int SYN_SK  = 0;
    localparam int SYN_DAT = 1;
    localparam int SYN_STB = 2;
    localparam int SYN_CLR = 3;
    localparam int SYN_W   = 4;

    // X occupies the low bits of the shift register, Y sits directly above it
    localparam int X_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HOLD   = 2'd2
    } stretch_state_t;

    function automatic int frame_bits(input int ay_bits, input int ax_bits);
        return ay_bits + ax_bits;
    endfunction

    function automatic int y_lsb(input int ax_bits);
        return ax_bits;
    endfunction

endpackage

// File: rtl/zx_pulse_stretch.sv
// Minimum-pulse stretcher for one special switch: output stays low for at
// least MIN_PULSE cycles and for as long as the switch cell remains closed.
module zx_pulse_stretch
    import zx_xpoint_pkg::*;
#(
    parameter int MIN_PULSE = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic cell_n,
    output logic pulse_n
);

    localparam int CW = (MIN_PULSE > 1) ? $clog2(MIN_PULSE) : 1;

    stretch_state_t state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // A release is only honoured once the minimum pulse has run out
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pulse_n  = 1'b1;
        case (state)
            ST_IDLE: begin
                if (!cell_n) begin
                    state_nx = ST_ACTIVE;
                    cnt_nx   = CW'(MIN_PULSE - 1);
                end
            end
            ST_ACTIVE: begin
                pulse_n = 1'b0;
                if (cnt == '0) begin
                    state_nx = cell_n ? ST_IDLE : ST_HOLD;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                pulse_n = 1'b0;
                if (cell_n) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/zx_xpoint_matrix.sv
// Clocked CH446Q-style serial crosspoint matrix feeding the ZX keyboard port,
// with a row of special switches driven through minimum-pulse stretchers.
module zx_xpoint_matrix
    import zx_xpoint_pkg::*;
#(
    parameter int AY_BITS     = 3,
    parameter int AX_BITS     = 4,
    parameter int ROWS        = 8,
    parameter int COLS        = 5,
    parameter int SPECIAL_X   = 8,
    parameter int N_SPEC      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_PULSE   = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SK,
    input  logic              DAT,
    input  logic              STB,
    input  logic              CLR,
    input  logic [ROWS-1:0]   A_HI,
    output logic [COLS-1:0]   KD,
    output logic [N_SPEC-1:0] SPEC_N,
    output logic              FRAME_ERR,
    input  logic              ERR_CLR
);

    localparam int F       = frame_bits(AY_BITS, AX_BITS);
    localparam int CW      = $clog2(F + 2);
    localparam int Y_LSB   = y_lsb(AX_BITS);
    localparam int SPEC_Y0 = 8 - N_SPEC;

    logic [SYN_W-1:0]   sync_q [SYNC_STAGES];
    logic [SYN_W-1:0]   sync_last;
    logic               sk_prev, stb_prev;
    logic               sk_rise, stb_rise, dat_q;
    logic               clr_s;

    logic [F-1:0]       shreg;
    logic [CW-1:0]      bit_cnt;
    logic [AY_BITS-1:0] y_f;
    logic [AX_BITS-1:0] x_f;
    logic               commit, bad_frame;
    logic               frame_err;

    logic [COLS-1:0]    cells [ROWS];
    logic [N_SPEC-1:0]  spec_cells;

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign clr_s     = sync_last[SYN_CLR];

    // Edge pulses are registered together with DAT so a shifted or committed
    // bit always pairs with the data that was stable around its edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            sk_prev  <= 1'b0;
            stb_prev <= 1'b0;
            sk_rise  <= 1'b0;
            stb_rise <= 1'b0;
            dat_q    <= 1'b0;
        end else begin
            sync_q[0] <= {CLR, STB, DAT, SK};
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            sk_prev  <= sync_last[SYN_SK];
            stb_prev <= sync_last[SYN_STB];
            sk_rise  <= sync_last[SYN_SK] & ~sk_prev;
            stb_rise <= sync_last[SYN_STB] & ~stb_prev;
            dat_q    <= sync_last[SYN_DAT];
        end
    end

    assign y_f = shreg[Y_LSB +: AY_BITS];
    assign x_f = shreg[X_LSB +: AX_BITS];

    always_comb begin
        commit    = 1'b0;
        bad_frame = 1'b0;
        if (stb_rise && !clr_s) begin
            commit    = (bit_cnt == CW'(F));
            bad_frame = (bit_cnt != CW'(F));
        end
    end

    // A strobe sharing a cycle with an SK edge closes the current frame with
    // the pre-shift count; that SK bit then opens the next frame as bit 1
    always_ff @(posedge CLK) begin
        if (RST) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            if (sk_rise) begin
                shreg <= {shreg[F-2:0], dat_q};
            end
            if (clr_s) begin
                bit_cnt <= '0;
            end else if (stb_rise) begin
                bit_cnt <= sk_rise ? CW'(1) : '0;
            end else if (sk_rise && bit_cnt != CW'(F + 1)) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int r = 0; r < ROWS; r++) begin
                cells[r] <= '1;
            end
            spec_cells <= '1;
        end else if (clr_s) begin
            for (int r = 0; r < ROWS; r++) begin
                cells[r] <= '1;
            end
            spec_cells <= '1;
        end else if (commit) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (x_f == AX_BITS'(r) && y_f == AY_BITS'(c)) begin
                        cells[r][c] <= dat_q;
                    end
                end
            end
            for (int i = 0; i < N_SPEC; i++) begin
                if (x_f == AX_BITS'(SPECIAL_X) && y_f == AY_BITS'(SPEC_Y0 + i)) begin
                    spec_cells[i] <= dat_q;
                end
            end
        end
    end

    // Setting takes priority so a clear cannot hide a fresh framing error
    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_err <= 1'b0;
        end else if (bad_frame) begin
            frame_err <= 1'b1;
        end else if (ERR_CLR) begin
            frame_err <= 1'b0;
        end
    end

    assign FRAME_ERR = frame_err;

    always_comb begin
        KD = '1;
        for (int r = 0; r < ROWS; r++) begin
            if (!A_HI[r]) begin
                KD = KD & cells[r];
            end
        end
    end

    for (genvar i = 0; i < N_SPEC; i++) begin : g_spec
        zx_pulse_stretch #(
            .MIN_PULSE (MIN_PULSE)
        ) u_stretch (
            .clk     (CLK),
            .rst     (RST),
            .cell_n  (spec_cells[i]),
            .pulse_n (SPEC_N[i])
        );
    end

endmodule

// File: tb/tb_zx_xpoint_matrix.sv
// Scoreboard bench for zx_xpoint_matrix: directed serial frames with
// hand-computed keyboard, special-pulse and frame-error expectations.
module tb_zx_xpoint_matrix;
    import zx_xpoint_pkg::*;

    localparam int K_KD    = 0;
    localparam int K_SPEC  = 1;
    localparam int K_FERR  = 2;
    localparam int K_WIDTH = 3;

    logic       CLK = 1'b0;
    logic       RST, SK, DAT, STB, CLR, ERR_CLR;
    logic [7:0] A_HI;
    logic [4:0] KD;
    logic [2:0] SPEC_N;
    logic       FRAME_ERR;

    typedef struct {
        int    kind;
        int    exp;
        string name;
    } exp_t;

    exp_t sbq[$];
    logic sample_req = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   run_len [3] = '{default: 0};
    int   last_width [3] = '{default: 0};
    int   p_cyc, r_cyc, dummy;

    zx_xpoint_matrix #(
        .AY_BITS(3), .AX_BITS(4), .ROWS(8), .COLS(5), .SPECIAL_X(8),
        .N_SPEC(3), .SYNC_STAGES(2), .MIN_PULSE(64)
    ) dut (
        .CLK(CLK), .RST(RST), .SK(SK), .DAT(DAT), .STB(STB), .CLR(CLR),
        .A_HI(A_HI), .KD(KD), .SPEC_N(SPEC_N), .FRAME_ERR(FRAME_ERR),
        .ERR_CLR(ERR_CLR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Measures the length of every low run on each special output
    always @(negedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            if (SPEC_N[i] == 1'b0) begin
                run_len[i] = run_len[i] + 1;
            end else begin
                if (run_len[i] != 0) last_width[i] = run_len[i];
                run_len[i] = 0;
            end
        end
    end

    task automatic checkOutput(input exp_t e);
        int act;
        case (e.kind)
            K_KD:    act = int'(KD);
            K_SPEC:  act = int'(SPEC_N);
            K_FERR:  act = int'(FRAME_ERR);
            default: act = last_width[e.kind - K_WIDTH];
        endcase
        checks++;
        if (act != e.exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     e.name, act, act, e.exp, e.exp);
        end
    endtask

    always @(negedge CLK) begin
        if (sample_req) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL scoreboard_empty: got 0 entries, expected 1");
            end else begin
                checkOutput(sbq.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input int kind, input logic [7:0] a_hi,
                                 input int exp, input string name);
        exp_t e;
        if (kind == K_KD) A_HI = a_hi;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sbq.push_back(e);
        sample_req = 1'b1;
        tick(1);
        sample_req = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        DAT = b;
        tick(1);
        SK = 1'b1;
        tick(2);
        SK = 1'b0;
        tick(1);
    endtask

    task automatic strobe(input logic d, output int stb_cyc);
        DAT = d;
        tick(1);
        STB = 1'b1;
        stb_cyc = cyc;
        tick(2);
        STB = 1'b0;
        tick(5);
    endtask

    task automatic send_frame(input int y, input int x, input logic d, output int stb_cyc);
        logic [6:0] bits;
        bits = {3'(y), 4'(x)};
        for (int i = 6; i >= 0; i--) send_bit(bits[i]);
        strobe(d, stb_cyc);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST = 1'b1; SK = 1'b0; DAT = 1'b0; STB = 1'b0; CLR = 1'b0;
        ERR_CLR = 1'b0; A_HI = 8'hFF;
        tick(5);
        RST = 1'b0;
        tick(3);

        applyStimulus(K_KD,   8'hFE, 5'b11111, "reset_kd_fe");
        applyStimulus(K_KD,   8'h7F, 5'b11111, "reset_kd_7f");
        applyStimulus(K_SPEC, 8'hFF, 3'b111,   "reset_spec_n");
        applyStimulus(K_FERR, 8'hFF, 0,        "reset_frame_err");

        send_frame(0, 0, 1'b0, dummy);
        send_frame(1, 1, 1'b0, dummy);
        send_frame(2, 2, 1'b0, dummy);
        send_frame(0, 3, 1'b1, dummy);
        send_frame(1, 3, 1'b0, dummy);
        send_frame(3, 3, 1'b0, dummy);
        send_frame(4, 4, 1'b0, dummy);
        send_frame(3, 5, 1'b0, dummy);
        send_frame(2, 6, 1'b0, dummy);
        send_frame(1, 7, 1'b0, dummy);
        applyStimulus(K_KD, 8'hFE, 5'b11110, "kd_fe");
        applyStimulus(K_KD, 8'hFD, 5'b11101, "kd_fd");
        applyStimulus(K_KD, 8'hFB, 5'b11011, "kd_fb");
        applyStimulus(K_KD, 8'hF7, 5'b10101, "kd_f7");
        applyStimulus(K_KD, 8'hEF, 5'b01111, "kd_ef");
        applyStimulus(K_KD, 8'hDF, 5'b10111, "kd_df");
        applyStimulus(K_KD, 8'hBF, 5'b11011, "kd_bf");
        applyStimulus(K_KD, 8'h7F, 5'b11101, "kd_7f");
        applyStimulus(K_KD, 8'h3F, 5'b11001, "kd_3f");

        // Outside the array: ignored without an error; X9 leaves bit 0 = 1
        send_frame(5, 0, 1'b0, dummy);
        send_frame(0, 8, 1'b0, dummy);
        send_frame(0, 9, 1'b0, dummy);
        applyStimulus(K_KD,   8'hFE, 5'b11110, "oor_kd_fe");
        applyStimulus(K_SPEC, 8'hFF, 3'b111,   "oor_spec_n");
        applyStimulus(K_FERR, 8'hFF, 0,        "oor_frame_err");

        // Six zero bits leave Y4,X0 in the register; it must not be written
        for (int i = 0; i < 6; i++) send_bit(1'b0);
        strobe(1'b0, dummy);
        applyStimulus(K_FERR, 8'hFF, 1,        "short_frame_err");
        applyStimulus(K_KD,   8'hFE, 5'b11110, "short_no_write");
        ERR_CLR = 1'b1;
        tick(1);
        ERR_CLR = 1'b0;
        tick(1);
        applyStimulus(K_FERR, 8'hFF, 0, "err_clr");
        send_frame(4, 0, 1'b0, dummy);
        applyStimulus(K_KD,   8'hFE, 5'b01110, "after_err_kd_fe");
        applyStimulus(K_FERR, 8'hFF, 0,        "after_err_frame_err");

        send_frame(5, 8, 1'b0, dummy);
        applyStimulus(K_SPEC, 8'hFF, 3'b110, "nmi_active");
        tick(10);
        send_frame(5, 8, 1'b1, dummy);
        tick(100);
        applyStimulus(K_WIDTH + SPEC_NMI, 8'hFF, 64, "nmi_width");

        send_frame(6, 8, 1'b0, p_cyc);
        tick(200);
        applyStimulus(K_SPEC, 8'hFF, 3'b101, "rst_hold");
        send_frame(6, 8, 1'b1, r_cyc);
        tick(20);
        applyStimulus(K_WIDTH + SPEC_RST, 8'hFF, r_cyc - p_cyc, "rst_width");
        applyStimulus(K_SPEC, 8'hFF, 3'b111, "rst_released");

        applyStimulus(K_KD, 8'h00, 5'b00000, "pre_clr_kd_00");
        send_frame(7, 8, 1'b0, dummy);
        applyStimulus(K_SPEC, 8'hFF, 3'b011, "bsrq_active");
        CLR = 1'b1;
        tick(3);
        CLR = 1'b0;
        tick(5);
        applyStimulus(K_KD,   8'h00, 5'b11111, "clr_kd_00");
        applyStimulus(K_SPEC, 8'hFF, 3'b011,   "clr_pulse_kept");
        tick(80);
        applyStimulus(K_WIDTH + SPEC_BSRQ, 8'hFF, 64, "bsrq_width");
        applyStimulus(K_SPEC, 8'hFF, 3'b111, "bsrq_released");

        // Y2,X0 = 010_0000 with its strobe aligned to an eighth SK edge (DAT 0),
        // which becomes the leading 0 of Y3,X1 = 011_0001
        for (int i = 0; i < 7; i++) send_bit(i == 1 ? 1'b1 : 1'b0);
        DAT = 1'b0;
        tick(1);
        SK = 1'b1;
        STB = 1'b1;
        tick(2);
        SK = 1'b0;
        STB = 1'b0;
        tick(5);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        strobe(1'b0, dummy);
        applyStimulus(K_KD,   8'hFE, 5'b11011, "aligned_kd_fe");
        applyStimulus(K_KD,   8'hFD, 5'b10111, "aligned_kd_fd");
        applyStimulus(K_FERR, 8'hFF, 0,        "aligned_frame_err");

        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        tick(3);
        applyStimulus(K_KD,   8'h00, 5'b11111, "midrst_kd_00");
        applyStimulus(K_FERR, 8'hFF, 0,        "midrst_frame_err");
        send_frame(0, 2, 1'b0, dummy);
        applyStimulus(K_KD,   8'hFB, 5'b11110, "midrst_kd_fb");
        applyStimulus(K_FERR, 8'hFF, 0,        "midrst_commit_ok");

        tick(3);
        if (sbq.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries, expected 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
